// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - instruction fetch requester with PC, SRAM request and 2-entry output FIFO
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        sram_ren_o,
  output logic [31:0] sram_raddr_o,
  input  logic [31:0] sram_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_pend;
  logic [1:0]  r_count;
  logic        r_wptr;
  logic        r_rptr;
  logic [31:0] r_inst_mem [2];
  logic [31:0] r_pc_mem   [2];

  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_credit;
  logic [31:0] w_redirect_pc;

  assign w_valid       = (r_count != 2'd0);
  assign w_pop         = w_valid & inst_ready_i;
  // A response in flight is discarded when a redirect lands in its capture cycle.
  assign w_push        = r_pend & ~redirect_valid_i;
  assign w_redirect_pc = redirect_pc_i & PC_MASK;

  // Slots already promised: buffered entries minus the one leaving, plus the one returning.
  assign w_credit = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_pend};
  // Reset gates issue so the SRAM sees no request while reset is held.
  assign w_issue  = ~rst_i & ~redirect_valid_i & (w_credit < 3'(DEPTH));

  assign sram_ren_o   = w_issue;
  assign sram_raddr_o = r_pc & PC_MASK;
  assign inst_valid_o = w_valid;
  assign inst_o       = w_valid ? r_inst_mem[r_rptr] : 32'h0;
  assign inst_pc_o    = w_valid ? r_pc_mem[r_rptr]   : 32'h0;

  // PC and in-flight tracking: redirect reloads the PC, issue advances it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc      <= RESET_PC & PC_MASK;
      r_pend    <= 1'b0;
      r_pend_pc <= 32'h0;
    end else begin
      r_pend <= w_issue;
      if (redirect_valid_i) begin
        r_pc <= w_redirect_pc;
      end else if (w_issue) begin
        r_pc      <= r_pc + 32'd4;
        r_pend_pc <= r_pc;
      end
    end
  end

  // FIFO occupancy and pointers; redirect empties the queue and ignores any pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else if (redirect_valid_i) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head mux.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_inst_mem[r_wptr] <= sram_rdata_i;
      r_pc_mem[r_wptr]   <= r_pend_pc;
    end
  end

endmodule
